// File: rtl/cmp_sched.sv
// rtl/cmp_sched.sv - round-robin scheduler sharing one magnitude comparator among NREQ requesters
module cmp_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       done,
  output logic                  res_gt,
  output logic                  res_eq,
  output logic                  res_lt,
  output logic                  err,
  output logic                  busy,
  output logic                  cmp_cs,
  output logic [WIDTH-1:0]      cmp_a,
  output logic [WIDTH-1:0]      cmp_b,
  input  logic                  cmp_ready,
  input  logic                  cmp_c,
  input  logic                  cmp_z
);

  localparam int IW = $clog2(NREQ);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   pick;
  logic [7:0]      timer;

  // Scan downward so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    pick = rr_ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) pick = IW'((int'(rr_ptr) + k) % NREQ);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
      timer  <= '0;
      cmp_cs <= 1'b0;
      cmp_a  <= '0;
      cmp_b  <= '0;
      done   <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
      res_gt <= 1'b0;
      res_eq <= 1'b0;
      res_lt <= 1'b0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (|req && cmp_ready) begin
            gnt    <= pick;
            cmp_a  <= a_in[pick*WIDTH +: WIDTH];
            cmp_b  <= b_in[pick*WIDTH +: WIDTH];
            cmp_cs <= 1'b1;
            busy   <= 1'b1;
            timer  <= '0;
            state  <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (timer == 8'(TIMEOUT)) begin
            // Watchdog abort: report an empty result flagged with err.
            cmp_cs <= 1'b0;
            res_gt <= 1'b0;
            res_eq <= 1'b0;
            res_lt <= 1'b0;
            err    <= 1'b1;
            done   <= ONE << gnt;
            state  <= DONE;
          end else begin
            timer <= timer + 8'd1;
            if (state == ISSUE) begin
              if (!cmp_ready) begin
                cmp_cs <= 1'b0;
                state  <= WAIT;
              end
            end else if (cmp_ready) begin
              res_gt <= cmp_c;
              res_eq <= cmp_z;
              res_lt <= ~cmp_c & ~cmp_z;
              done   <= ONE << gnt;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          rr_ptr <= (gnt == IW'(NREQ - 1)) ? '0 : gnt + 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sched.sv
// tb/tb_cmp_sched.sv - directed self-checking bench for cmp_sched
module tb_cmp_sched;
  localparam int NREQ = 4, WIDTH = 16, TIMEOUT = 15;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] a_in = '0;
  logic [NREQ*WIDTH-1:0] b_in = '0;
  logic [NREQ-1:0]       done;
  logic                  res_gt, res_eq, res_lt, err, busy, cmp_cs;
  logic [WIDTH-1:0]      cmp_a, cmp_b;
  logic                  cmp_ready = 1'b1;
  logic                  cmp_c = 1'b0;
  logic                  cmp_z = 1'b0;

  logic                  mbusy = 1'b0;
  logic                  stall = 1'b0;
  logic [WIDTH-1:0]      ma = '0, mb = '0;
  int                    n_checks = 0;
  int                    n_fail = 0;

  cmp_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .done(done), .res_gt(res_gt), .res_eq(res_eq), .res_lt(res_lt),
    .err(err), .busy(busy), .cmp_cs(cmp_cs), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_ready(cmp_ready), .cmp_c(cmp_c), .cmp_z(cmp_z)
  );

  always #5 clk = ~clk;

  // Comparator: drops ready the edge after it sees cs, returns flags one edge later.
  always @(posedge clk) begin
    if (mbusy) begin
      cmp_ready <= 1'b1;
      cmp_c     <= (ma > mb);
      cmp_z     <= (ma == mb);
      mbusy     <= 1'b0;
    end else if (cmp_cs && cmp_ready && !stall) begin
      cmp_ready <= 1'b0;
      ma        <= cmp_a;
      mb        <= cmp_b;
      mbusy     <= 1'b1;
    end
  end

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_done(input int budget, output int lat, output int cs_cnt);
    lat = 0;
    cs_cnt = 0;
    do begin
      @(negedge clk);
      lat++;
      if (cmp_cs) cs_cnt++;
    end while (done == '0 && lat < budget);
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b want 0000", done); end
    n_checks++; if ({err, busy, cmp_cs} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b want 000", {err, busy, cmp_cs}); end
    n_checks++; if ({res_gt, res_eq, res_lt} !== 3'b000) begin n_fail++; $display("FAIL reset_res: got %b want 000", {res_gt, res_eq, res_lt}); end
    n_checks++; if ({cmp_a, cmp_b} !== 32'h0) begin n_fail++; $display("FAIL reset_ops: got %h want 0", {cmp_a, cmp_b}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin;
    int lat, csn;
    int exp_g [5] = '{0, 1, 2, 3, 0};
    logic [2:0] exp_f [5] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b100};
    logic [NREQ-1:0] ed;
    set_op(0, 16'h0005, 16'h0003);
    set_op(1, 16'h1234, 16'h1234);
    set_op(2, 16'h0002, 16'h8000);
    set_op(3, 16'hFFFF, 16'h0000);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_done(40, lat, csn);
      ed = 4'b0001 << exp_g[i];
      n_checks++; if (done !== ed) begin n_fail++; $display("FAIL rr_done[%0d]: got %b want %b", i, done, ed); end
      n_checks++; if ({res_gt, res_eq, res_lt} !== exp_f[i]) begin n_fail++; $display("FAIL rr_res[%0d]: got %b want %b", i, {res_gt, res_eq, res_lt}, exp_f[i]); end
      n_checks++; if (lat !== ((i == 0) ? 4 : 5)) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", i, lat, (i == 0) ? 4 : 5); end
      if (i == 4) req = '0;
    end
    @(negedge clk);
  endtask

  task automatic test_single;
    int lat, csn;
    set_op(0, 16'h0030, 16'h0010);
    req = 4'b0001;
    wait_done(20, lat, csn);
    req = '0;
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL single_lat: got %0d want 4", lat); end
    n_checks++; if (csn !== 2) begin n_fail++; $display("FAIL single_cs_cycles: got %0d want 2", csn); end
    n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b want 0001", done); end
    n_checks++; if ({res_gt, res_eq, res_lt, err} !== 4'b1000) begin n_fail++; $display("FAIL single_res: got %b want 1000", {res_gt, res_eq, res_lt, err}); end
    @(negedge clk);
    n_checks++; if (done !== 4'b0000) begin n_fail++; $display("FAIL single_pulse_width: got %b want 0000", done); end
  endtask

  task automatic test_equal_less;
    int lat, csn;
    set_op(2, 16'hBEEF, 16'hBEEF);
    req = 4'b0100;
    wait_done(20, lat, csn);
    req = '0;
    n_checks++; if (done !== 4'b0100) begin n_fail++; $display("FAIL eq_done: got %b want 0100", done); end
    n_checks++; if ({res_gt, res_eq, res_lt} !== 3'b010) begin n_fail++; $display("FAIL eq_res: got %b want 010", {res_gt, res_eq, res_lt}); end
    @(negedge clk);
    set_op(2, 16'h0001, 16'hFFFF);
    req = 4'b0100;
    @(negedge clk);
    set_op(2, 16'hFFFF, 16'hFFFF);
    wait_done(20, lat, csn);
    req = '0;
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL lt_lat: got %0d want 3", lat); end
    n_checks++; if (done !== 4'b0100) begin n_fail++; $display("FAIL lt_done: got %b want 0100", done); end
    n_checks++; if ({res_gt, res_eq, res_lt} !== 3'b001) begin n_fail++; $display("FAIL lt_res: got %b want 001", {res_gt, res_eq, res_lt}); end
    n_checks++; if (cmp_a !== 16'h0001) begin n_fail++; $display("FAIL lt_operand_hold: got %h want 0001", cmp_a); end
  endtask

  task automatic test_wrap;
    int lat, csn;
    set_op(0, 16'h0007, 16'h0009);
    set_op(3, 16'h8000, 16'h7FFF);
    req = 4'b1001;
    wait_done(20, lat, csn);
    n_checks++; if (done !== 4'b1000) begin n_fail++; $display("FAIL wrap_first: got %b want 1000", done); end
    n_checks++; if ({res_gt, res_eq, res_lt} !== 3'b100) begin n_fail++; $display("FAIL wrap_first_res: got %b want 100", {res_gt, res_eq, res_lt}); end
    req = 4'b0001;
    wait_done(20, lat, csn);
    req = '0;
    n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL wrap_second: got %b want 0001", done); end
    n_checks++; if ({res_gt, res_eq, res_lt} !== 3'b001) begin n_fail++; $display("FAIL wrap_second_res: got %b want 001", {res_gt, res_eq, res_lt}); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL wrap_spacing: got %0d want 5", lat); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int lat, csn;
    stall = 1'b1;
    set_op(1, 16'h0003, 16'h0004);
    req = 4'b0010;
    wait_done(60, lat, csn);
    req = '0;
    n_checks++; if (lat !== TIMEOUT + 2) begin n_fail++; $display("FAIL to_lat: got %0d want %0d", lat, TIMEOUT + 2); end
    n_checks++; if (done !== 4'b0010) begin n_fail++; $display("FAIL to_done: got %b want 0010", done); end
    n_checks++; if ({err, cmp_cs} !== 2'b10) begin n_fail++; $display("FAIL to_err_cs: got %b want 10", {err, cmp_cs}); end
    n_checks++; if ({res_gt, res_eq, res_lt} !== 3'b000) begin n_fail++; $display("FAIL to_res: got %b want 000", {res_gt, res_eq, res_lt}); end
    @(negedge clk);
    n_checks++; if ({err, done} !== 5'b0) begin n_fail++; $display("FAIL to_pulse_width: got %b want 00000", {err, done}); end
    stall = 1'b0;
    set_op(2, 16'h0010, 16'h0005);
    req = 4'b0100;
    wait_done(20, lat, csn);
    req = '0;
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL to_next_lat: got %0d want 4", lat); end
    n_checks++; if ({done, err} !== 5'b01000) begin n_fail++; $display("FAIL to_next_done: got %b want 01000", {done, err}); end
    n_checks++; if ({res_gt, res_eq, res_lt} !== 3'b100) begin n_fail++; $display("FAIL to_next_res: got %b want 100", {res_gt, res_eq, res_lt}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int lat, csn;
    logic [NREQ-1:0] seen;
    set_op(2, 16'h1111, 16'h2222);
    req = 4'b0100;
    repeat (3) @(negedge clk);
    n_checks++; if ({busy, cmp_cs} !== 2'b10) begin n_fail++; $display("FAIL rst_in_wait: got %b want 10", {busy, cmp_cs}); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({done, err, busy, cmp_cs} !== 7'b0) begin n_fail++; $display("FAIL rst_async_ctl: got %b want 0000000", {done, err, busy, cmp_cs}); end
    n_checks++; if ({res_gt, res_eq, res_lt} !== 3'b000) begin n_fail++; $display("FAIL rst_async_res: got %b want 000", {res_gt, res_eq, res_lt}); end
    n_checks++; if ({cmp_a, cmp_b} !== 32'h0) begin n_fail++; $display("FAIL rst_async_ops: got %h want 0", {cmp_a, cmp_b}); end
    req = '0;
    seen = '0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | done;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      seen = seen | done;
    end
    n_checks++; if (seen !== 4'b0000) begin n_fail++; $display("FAIL rst_no_done: got %b want 0000", seen); end
    set_op(1, 16'h00AA, 16'h00AA);
    req = 4'b0010;
    wait_done(20, lat, csn);
    req = '0;
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rst_after_lat: got %0d want 4", lat); end
    n_checks++; if ({done, err} !== 5'b00100) begin n_fail++; $display("FAIL rst_after_done: got %b want 00100", {done, err}); end
    n_checks++; if ({res_gt, res_eq, res_lt} !== 3'b010) begin n_fail++; $display("FAIL rst_after_res: got %b want 010", {res_gt, res_eq, res_lt}); end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_equal_less;
    test_wrap;
    test_timeout;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded 100000 time units");
    $fatal(1);
  end

endmodule
